rv32i_decode_execute: RTL and testbench
=======================================

Name: rv32i_decode_execute

Overview:
- RV32I instruction decoder (ID stage, combinational) and execute unit (EX stage: ALU, branch/jump resolution, write-back candidate select, combinational).
- Also contains the EX/MEM pipeline register (clocked).
- The decoder feeds the external ID/EX register; the EX half takes forwarded operands from ID/EX and registers its results for the MEM stage.

Parameters:
- XLEN, 32, datapath width (fixed at 32).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_inst  in  32  instruction in ID.
- rs1_addr, rs2_addr, rd_addr  out  5  inst[19:15], inst[24:20], inst[11:7].
- funct3  out  3  inst[14:12]. funct7  out  7  inst[31:25].
- imm_type  out  3  I=0, S=1, B=2, U=3, J=4.
- reg_write, mem_read, mem_write, branch, jal, jalr, alu_rs2_imm, use_pc_add, load_signed  out  1  decode controls.
- branch_op  out  3  = funct3 for branches, else 0.
- alu_op  out  4  ALU code.
- wb_sel  out  2  00 ALU, 01 MEM, 10 PC+4, 11 IMM.
- load_size, store_size  out  2  00 byte, 01 half, 10 word.
- ecall, ebreak, fence  out  1  system decode.
- ex_pc, ex_rs1, ex_rs2, ex_imm  in  32  EX operands; ex_rs2 is the forwarded rs2, before immediate select.
- ex_alu_op  in  4; ex_alu_rs2_imm, ex_branch, ex_jal, ex_jalr, ex_use_pc_add  in  1; ex_branch_op  in  3; ex_wb_sel  in  2.
- ex_alu_result, ex_pc_plus4, ex_branch_target  out  32  EX combinational results.
- ex_redirect_taken  out  1  control-flow redirect.
- ex_rd_addr  in  5.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_load_signed, ex_csr_hit, ex_ecall, ex_ebreak, ex_fence  in  1.
- ex_load_size, ex_store_size  in  2. ex_csr_data  in  32.
- mem_pc, mem_alu_result, mem_rs2_val_for_store, mem_wb_candidate, mem_csr_data  out  32  registered.
- mem_rd_addr  out  5; mem_wb_sel, mem_load_size, mem_store_size  out  2  registered.
- mem_reg_write, mem_mem_read, mem_mem_write, mem_load_signed, mem_csr_hit, mem_ecall, mem_ebreak, mem_fence  out  1  registered.

Behaviour:
- Decoder, by opcode. Unlisted opcodes drive all controls to 0.
  - OP (0110011): reg_write=1; alu from funct3/funct7[5].
  - OP-IMM (0010011): reg_write=1, alu_rs2_imm=1, imm I. SRAI when inst[30]=1; ADDI ignores inst[30].
  - LOAD (0000011): mem_read, reg_write, rs2_imm, ADD, wb 01, imm I. load_size=funct3[1:0]; load_signed=~funct3[2].
  - STORE (0100011): mem_write, rs2_imm, ADD, imm S, store_size=funct3[1:0].
  - BRANCH (1100011): branch=1, branch_op=funct3, imm B.
  - JAL (1101111): jal, reg_write, wb 10, imm J.
  - JALR (1100111): jalr, reg_write, wb 10, imm I.
  - LUI (0110111): reg_write, wb 11, imm U.
  - AUIPC (0010111): reg_write, use_pc_add, imm U.
  - MISC-MEM (0001111): fence=1.
  - SYSTEM: 0x00000073 gives ecall=1; 0x00100073 gives ebreak=1. CSR forms give reg_write=0 (CSR value is supplied externally through csr_hit).
- ALU codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Codes 10-15 give result 0.
  - Shift amount is operand B[4:0].
  - Operand A = ex_rs1; operand B = ex_alu_rs2_imm ? ex_imm : ex_rs2.
- Branch conditions compare ex_rs1 with ex_rs2 (never the immediate): 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Branch_op 010/011 is never taken.
- ex_pc_plus4 = ex_pc+4, mod 2^32.
- ex_branch_target = ex_jalr ? (ex_rs1+ex_imm) & ~1 : ex_pc+ex_imm.
- ex_redirect_taken = ex_jal | ex_jalr | (ex_branch & cond).
- Write-back candidate, by priority:
  - ex_use_pc_add gives ex_pc+ex_imm;
  - else wb_sel 10 gives pc+4;
  - else wb_sel 11 gives ex_imm;
  - else the ALU result.
- EX/MEM register updates every rising clk, with no stall or flush. mem_rs2_val_for_store takes ex_rs2 (forwarded, unmuxed).
- On rst assertion, all mem_* outputs go to 0 immediately (asynchronous) and hold 0 while rst=1.

Test Plan:
- id_inst=0x00100393 (addi x7,x0,1) -> rd=7, reg_write=1, alu_rs2_imm=1, alu_op=0, wb_sel=00, imm_type=0.
- id_inst=0x40B50533 (sub) -> alu_op=1. id_inst=0x4030D093 (srai) -> alu_op=7. Illegal 0xFFFFFFFF -> all controls 0.
- EX with alu_op=SLT, rs1=0xFFFFFFFF, rs2=1 -> result 1. SLTU on the same operands -> result 0. SRA of 0x80000000 by 4 -> 0xF8000000.
- ex_branch=1, op=BNE, rs1=rs2=5 -> taken=0; op=BGEU, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=-8 -> taken=1, target=0xF8.
- ex_jalr=1, rs1=0x1003, imm=4, pc=0x40, wb_sel=10 -> target=0x1006, taken=1; after the next clk, mem_wb_candidate=0x44.
- Drive nonzero EX inputs, clock, then assert rst between edges -> all mem_* outputs 0 immediately. Deassert rst, clock -> outputs reload.

Source files
------------

// File: rtl/rv32i_decode_execute.sv
// RV32I decode (ID, combinational) and execute (EX, combinational) with the
// EX/MEM pipeline register feeding the memory stage.
module rv32i_decode_execute #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    // ID stage
    input  logic [31:0]     id_inst,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [2:0]      imm_type,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jal,
    output logic            jalr,
    output logic            alu_rs2_imm,
    output logic            use_pc_add,
    output logic            load_signed,
    output logic [2:0]      branch_op,
    output logic [3:0]      alu_op,
    output logic [1:0]      wb_sel,
    output logic [1:0]      load_size,
    output logic [1:0]      store_size,
    output logic            ecall,
    output logic            ebreak,
    output logic            fence,
    // EX stage
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [3:0]      ex_alu_op,
    input  logic            ex_alu_rs2_imm,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic            ex_use_pc_add,
    input  logic [2:0]      ex_branch_op,
    input  logic [1:0]      ex_wb_sel,
    output logic [XLEN-1:0] ex_alu_result,
    output logic [XLEN-1:0] ex_pc_plus4,
    output logic [XLEN-1:0] ex_branch_target,
    output logic            ex_redirect_taken,
    input  logic [4:0]      ex_rd_addr,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_load_signed,
    input  logic            ex_csr_hit,
    input  logic            ex_ecall,
    input  logic            ex_ebreak,
    input  logic            ex_fence,
    input  logic [1:0]      ex_load_size,
    input  logic [1:0]      ex_store_size,
    input  logic [XLEN-1:0] ex_csr_data,
    // EX/MEM register
    output logic [XLEN-1:0] mem_pc,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_rs2_val_for_store,
    output logic [XLEN-1:0] mem_wb_candidate,
    output logic [XLEN-1:0] mem_csr_data,
    output logic [4:0]      mem_rd_addr,
    output logic [1:0]      mem_wb_sel,
    output logic [1:0]      mem_load_size,
    output logic [1:0]      mem_store_size,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            mem_load_signed,
    output logic            mem_csr_hit,
    output logic            mem_ecall,
    output logic            mem_ebreak,
    output logic            mem_fence
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OPIMM  = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_MISC   = 7'b0001111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    // alt selects SUB/SRA; OP-IMM only forwards it for the shift-right form
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;

    assign opcode   = id_inst[6:0];
    assign rs1_addr = id_inst[19:15];
    assign rs2_addr = id_inst[24:20];
    assign rd_addr  = id_inst[11:7];
    assign funct3   = id_inst[14:12];
    assign funct7   = id_inst[31:25];

    always_comb begin
        imm_type    = IMM_I;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        jal         = 1'b0;
        jalr        = 1'b0;
        alu_rs2_imm = 1'b0;
        use_pc_add  = 1'b0;
        load_signed = 1'b0;
        branch_op   = '0;
        alu_op      = ALU_ADD;
        wb_sel      = WB_ALU;
        load_size   = '0;
        store_size  = '0;
        ecall       = 1'b0;
        ebreak      = 1'b0;
        fence       = 1'b0;
        case (opcode)
            OPC_OP: begin
                reg_write = 1'b1;
                alu_op    = alu_decode(funct3, id_inst[30]);
            end
            OPC_OPIMM: begin
                reg_write   = 1'b1;
                alu_rs2_imm = 1'b1;
                alu_op      = alu_decode(funct3, (funct3 == 3'b101) && id_inst[30]);
            end
            OPC_LOAD: begin
                mem_read    = 1'b1;
                reg_write   = 1'b1;
                alu_rs2_imm = 1'b1;
                wb_sel      = WB_MEM;
                load_size   = funct3[1:0];
                load_signed = ~funct3[2];
            end
            OPC_STORE: begin
                mem_write   = 1'b1;
                alu_rs2_imm = 1'b1;
                imm_type    = IMM_S;
                store_size  = funct3[1:0];
            end
            OPC_BRANCH: begin
                branch    = 1'b1;
                branch_op = funct3;
                imm_type  = IMM_B;
            end
            OPC_JAL: begin
                jal       = 1'b1;
                reg_write = 1'b1;
                wb_sel    = WB_PC4;
                imm_type  = IMM_J;
            end
            OPC_JALR: begin
                jalr      = 1'b1;
                reg_write = 1'b1;
                wb_sel    = WB_PC4;
            end
            OPC_LUI: begin
                reg_write = 1'b1;
                wb_sel    = WB_IMM;
                imm_type  = IMM_U;
            end
            OPC_AUIPC: begin
                reg_write  = 1'b1;
                use_pc_add = 1'b1;
                imm_type   = IMM_U;
            end
            OPC_MISC: fence = 1'b1;
            // CSR forms leave reg_write low; their value arrives via csr_hit
            OPC_SYSTEM: begin
                ecall  = (id_inst == 32'h0000_0073);
                ebreak = (id_inst == 32'h0010_0073);
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] rs1_imm;
    logic            cond;
    logic [XLEN-1:0] wb_candidate;

    assign op_b    = ex_alu_rs2_imm ? ex_imm : ex_rs2;
    assign shamt   = op_b[4:0];
    assign pc_imm  = ex_pc + ex_imm;
    assign rs1_imm = ex_rs1 + ex_imm;

    always_comb begin
        ex_alu_result = '0;
        case (ex_alu_op)
            ALU_ADD:  ex_alu_result = ex_rs1 + op_b;
            ALU_SUB:  ex_alu_result = ex_rs1 - op_b;
            ALU_SLL:  ex_alu_result = ex_rs1 << shamt;
            ALU_SLT:  ex_alu_result = {{(XLEN-1){1'b0}}, $signed(ex_rs1) < $signed(op_b)};
            ALU_SLTU: ex_alu_result = {{(XLEN-1){1'b0}}, ex_rs1 < op_b};
            ALU_XOR:  ex_alu_result = ex_rs1 ^ op_b;
            ALU_SRL:  ex_alu_result = ex_rs1 >> shamt;
            ALU_SRA:  ex_alu_result = $unsigned($signed(ex_rs1) >>> shamt);
            ALU_OR:   ex_alu_result = ex_rs1 | op_b;
            ALU_AND:  ex_alu_result = ex_rs1 & op_b;
            default:  ex_alu_result = '0;
        endcase
    end

    // Branches always compare the register operands, never the immediate
    always_comb begin
        cond = 1'b0;
        case (ex_branch_op)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond = (ex_rs1 <  ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b0;
        endcase
    end

    assign ex_pc_plus4       = ex_pc + XLEN'(4);
    assign ex_branch_target  = ex_jalr ? {rs1_imm[XLEN-1:1], 1'b0} : pc_imm;
    assign ex_redirect_taken = ex_jal | ex_jalr | (ex_branch & cond);

    always_comb begin
        if (ex_use_pc_add)
            wb_candidate = pc_imm;
        else if (ex_wb_sel == WB_PC4)
            wb_candidate = ex_pc_plus4;
        else if (ex_wb_sel == WB_IMM)
            wb_candidate = ex_imm;
        else
            wb_candidate = ex_alu_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_pc                <= '0;
            mem_alu_result        <= '0;
            mem_rs2_val_for_store <= '0;
            mem_wb_candidate      <= '0;
            mem_csr_data          <= '0;
            mem_rd_addr           <= '0;
            mem_wb_sel            <= '0;
            mem_load_size         <= '0;
            mem_store_size        <= '0;
            mem_reg_write         <= 1'b0;
            mem_mem_read          <= 1'b0;
            mem_mem_write         <= 1'b0;
            mem_load_signed       <= 1'b0;
            mem_csr_hit           <= 1'b0;
            mem_ecall             <= 1'b0;
            mem_ebreak            <= 1'b0;
            mem_fence             <= 1'b0;
        end else begin
            mem_pc                <= ex_pc;
            mem_alu_result        <= ex_alu_result;
            mem_rs2_val_for_store <= ex_rs2;
            mem_wb_candidate      <= wb_candidate;
            mem_csr_data          <= ex_csr_data;
            mem_rd_addr           <= ex_rd_addr;
            mem_wb_sel            <= ex_wb_sel;
            mem_load_size         <= ex_load_size;
            mem_store_size        <= ex_store_size;
            mem_reg_write         <= ex_reg_write;
            mem_mem_read          <= ex_mem_read;
            mem_mem_write         <= ex_mem_write;
            mem_load_signed       <= ex_load_signed;
            mem_csr_hit           <= ex_csr_hit;
            mem_ecall             <= ex_ecall;
            mem_ebreak            <= ex_ebreak;
            mem_fence             <= ex_fence;
        end
    end

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Randomized bench for rv32i_decode_execute: instructions are built by an
// encoder that knows the expected decode, EX results come from a plain model.
module tb_rv32i_decode_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_inst;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [2:0]  imm_type;
    logic        reg_write, mem_read, mem_write, branch, jal, jalr;
    logic        alu_rs2_imm, use_pc_add, load_signed;
    logic [2:0]  branch_op;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel, load_size, store_size;
    logic        ecall, ebreak, fence;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_rs2_imm, ex_branch, ex_jal, ex_jalr, ex_use_pc_add;
    logic [2:0]  ex_branch_op;
    logic [1:0]  ex_wb_sel;
    logic [31:0] ex_alu_result, ex_pc_plus4, ex_branch_target;
    logic        ex_redirect_taken;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_load_signed;
    logic        ex_csr_hit, ex_ecall, ex_ebreak, ex_fence;
    logic [1:0]  ex_load_size, ex_store_size;
    logic [31:0] ex_csr_data;
    logic [31:0] mem_pc, mem_alu_result, mem_rs2_val_for_store, mem_wb_candidate, mem_csr_data;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel, mem_load_size, mem_store_size;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_load_signed;
    logic        mem_csr_hit, mem_ecall, mem_ebreak, mem_fence;

    always #5 clk = ~clk;

    rv32i_decode_execute #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_inst(id_inst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .funct3(funct3), .funct7(funct7), .imm_type(imm_type),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jal(jal), .jalr(jalr), .alu_rs2_imm(alu_rs2_imm),
        .use_pc_add(use_pc_add), .load_signed(load_signed), .branch_op(branch_op),
        .alu_op(alu_op), .wb_sel(wb_sel), .load_size(load_size), .store_size(store_size),
        .ecall(ecall), .ebreak(ebreak), .fence(fence),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_alu_op(ex_alu_op), .ex_alu_rs2_imm(ex_alu_rs2_imm), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_use_pc_add(ex_use_pc_add),
        .ex_branch_op(ex_branch_op), .ex_wb_sel(ex_wb_sel),
        .ex_alu_result(ex_alu_result), .ex_pc_plus4(ex_pc_plus4),
        .ex_branch_target(ex_branch_target), .ex_redirect_taken(ex_redirect_taken),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_load_signed(ex_load_signed), .ex_csr_hit(ex_csr_hit),
        .ex_ecall(ex_ecall), .ex_ebreak(ex_ebreak), .ex_fence(ex_fence),
        .ex_load_size(ex_load_size), .ex_store_size(ex_store_size), .ex_csr_data(ex_csr_data),
        .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
        .mem_rs2_val_for_store(mem_rs2_val_for_store), .mem_wb_candidate(mem_wb_candidate),
        .mem_csr_data(mem_csr_data), .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
        .mem_load_size(mem_load_size), .mem_store_size(mem_store_size),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_load_signed(mem_load_signed),
        .mem_csr_hit(mem_csr_hit), .mem_ecall(mem_ecall), .mem_ebreak(mem_ebreak),
        .mem_fence(mem_fence)
    );

    typedef struct packed {
        logic       rw, mr, mw, br, jal, jalr, rs2i, pcadd, lsgn;
        logic [2:0] bop;
        logic [3:0] alu;
        logic [1:0] wb, lsz, ssz;
        logic       ecall, ebreak, fence;
        logic [2:0] immt;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc, alu, rs2, wbc, csr;
        logic [4:0]  rd;
        logic [1:0]  wbs, lsz, ssz;
        logic        rw, mr, mw, lsgn, csrh, ecall, ebreak, fence;
    } memv_t;

    dec_t  dut_dec;
    memv_t dut_mem;
    assign dut_dec = {reg_write, mem_read, mem_write, branch, jal, jalr, alu_rs2_imm,
                      use_pc_add, load_signed, branch_op, alu_op, wb_sel, load_size,
                      store_size, ecall, ebreak, fence, imm_type};
    assign dut_mem = {mem_pc, mem_alu_result, mem_rs2_val_for_store, mem_wb_candidate,
                      mem_csr_data, mem_rd_addr, mem_wb_sel, mem_load_size, mem_store_size,
                      mem_reg_write, mem_mem_read, mem_mem_write, mem_load_signed,
                      mem_csr_hit, mem_ecall, mem_ebreak, mem_fence};

    int checks = 0;
    int errors = 0;
    logic        chk_en = 1'b0;
    logic        dec_valid = 1'b0;
    logic [31:0] exp_inst;
    dec_t        exp_dec;
    logic [31:0] exp_alu, exp_pc4, exp_tgt;
    logic        exp_taken;
    memv_t       exp_next, exp_mem;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Register-form mnemonics in ALU-code order: funct3 and funct7[5] for each
    localparam logic [2:0] F3_TAB [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    localparam logic       ALT_TAB[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    function automatic logic opcode_listed(input logic [6:0] opc);
        logic [6:0] tab [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
        foreach (tab[i]) if (tab[i] == opc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic gen_inst(output logic [31:0] inst, output dec_t e);
        logic [4:0]  rd  = 5'($urandom);
        logic [4:0]  rs1 = 5'($urandom);
        logic [4:0]  rs2 = 5'($urandom);
        logic [11:0] i12 = 12'($urandom);
        logic [2:0]  f3;
        logic [6:0]  opc;
        int unsigned k;
        e = '0;
        case ($urandom_range(0, 13))
            0: begin
                k = $urandom_range(0, 9);
                inst = {ALT_TAB[k] ? 7'b0100000 : 7'b0000000, rs2, rs1, F3_TAB[k], rd, 7'b0110011};
                e.rw = 1'b1; e.alu = 4'(k);
            end
            1: begin
                k = $urandom_range(0, 8);
                if (k >= 1) k++;
                f3 = F3_TAB[k];
                if (f3 == 3'd1 || f3 == 3'd5)
                    inst = {ALT_TAB[k] ? 7'b0100000 : 7'b0000000, rs2, rs1, f3, rd, 7'b0010011};
                else
                    inst = {i12, rs1, f3, rd, 7'b0010011};
                e.rw = 1'b1; e.rs2i = 1'b1; e.alu = 4'(k);
            end
            2: begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
                inst = {i12, rs1, f3, rd, 7'b0000011};
                e.rw = 1'b1; e.mr = 1'b1; e.rs2i = 1'b1; e.wb = 2'b01;
                e.lsz = f3[1:0]; e.lsgn = !f3[2];
            end
            3: begin
                f3 = 3'($urandom_range(0, 2));
                inst = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'b0100011};
                e.mw = 1'b1; e.rs2i = 1'b1; e.ssz = f3[1:0]; e.immt = 3'd1;
            end
            4: begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4; 3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                inst = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'b1100011};
                e.br = 1'b1; e.bop = f3; e.immt = 3'd2;
            end
            5: begin
                inst = {25'($urandom), 7'b1101111};
                e.jal = 1'b1; e.rw = 1'b1; e.wb = 2'b10; e.immt = 3'd4;
            end
            6: begin
                inst = {i12, rs1, 3'b000, rd, 7'b1100111};
                e.jalr = 1'b1; e.rw = 1'b1; e.wb = 2'b10;
            end
            7: begin
                inst = {20'($urandom), rd, 7'b0110111};
                e.rw = 1'b1; e.wb = 2'b11; e.immt = 3'd3;
            end
            8: begin
                inst = {20'($urandom), rd, 7'b0010111};
                e.rw = 1'b1; e.pcadd = 1'b1; e.immt = 3'd3;
            end
            9: begin
                inst = {i12, rs1, 3'b000, rd, 7'b0001111};
                e.fence = 1'b1;
            end
            10: begin inst = 32'h0000_0073; e.ecall = 1'b1; end
            11: begin inst = 32'h0010_0073; e.ebreak = 1'b1; end
            12: begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd1; 1: f3 = 3'd2; 2: f3 = 3'd3; 3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                inst = {i12, rs1, f3, rd, 7'b1110011};
            end
            default: begin
                do opc = 7'($urandom); while (opcode_listed(opc));
                inst = {25'($urandom), opc};
            end
        endcase
    endtask

    function automatic logic lt_signed(input logic [31:0] a, input logic [31:0] b);
        return (a[31] != b[31]) ? a[31] : (a < b);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int unsigned sh = b[4:0];
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return {31'b0, lt_signed(a, b)};
            4'd4: return {31'b0, a < b};
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: begin ext = {{32{a[31]}}, a} >> sh; return ext[31:0]; end
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return lt_signed(a, b);
            3'd5: return !lt_signed(a, b);
            3'd6: return a < b;
            3'd7: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_ex();
        logic [31:0] b = ex_alu_rs2_imm ? ex_imm : ex_rs2;
        logic [31:0] wbc;
        exp_alu   = alu_ref(ex_alu_op, ex_rs1, b);
        exp_pc4   = ex_pc + 32'd4;
        exp_tgt   = ex_jalr ? ((ex_rs1 + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
        exp_taken = ex_jal || ex_jalr || (ex_branch && br_ref(ex_branch_op, ex_rs1, ex_rs2));
        if (ex_use_pc_add)        wbc = ex_pc + ex_imm;
        else if (ex_wb_sel == 2)  wbc = exp_pc4;
        else if (ex_wb_sel == 3)  wbc = ex_imm;
        else                      wbc = exp_alu;
        exp_next = {ex_pc, exp_alu, ex_rs2, wbc, ex_csr_data, ex_rd_addr, ex_wb_sel,
                    ex_load_size, ex_store_size, ex_reg_write, ex_mem_read, ex_mem_write,
                    ex_load_signed, ex_csr_hit, ex_ecall, ex_ebreak, ex_fence};
    endtask

    task automatic drive_random();
        gen_inst(exp_inst, exp_dec);
        id_inst   = exp_inst;
        dec_valid = 1'b1;
        ex_pc  = $urandom & 32'hFFFF_FFFC;
        ex_rs1 = $urandom;
        ex_rs2 = ($urandom_range(0, 3) == 0) ? ex_rs1 : $urandom;
        ex_imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
        ex_alu_op      = 4'($urandom);
        ex_alu_rs2_imm = 1'($urandom);
        ex_branch      = 1'($urandom);
        ex_jal         = ($urandom_range(0, 5) == 0);
        ex_jalr        = ($urandom_range(0, 5) == 0);
        ex_use_pc_add  = ($urandom_range(0, 3) == 0);
        ex_branch_op   = 3'($urandom);
        ex_wb_sel      = 2'($urandom);
        ex_rd_addr     = 5'($urandom);
        {ex_reg_write, ex_mem_read, ex_mem_write, ex_load_signed,
         ex_csr_hit, ex_ecall, ex_ebreak, ex_fence} = 8'($urandom);
        ex_load_size   = 2'($urandom);
        ex_store_size  = 2'($urandom);
        ex_csr_data    = $urandom;
        model_ex();
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) exp_mem = exp_next;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (dec_valid) begin
                chk("decode_ctrl", dut_dec, exp_dec);
                chk("decode_fields", {rs1_addr, rs2_addr, rd_addr, funct3, funct7},
                    {exp_inst[19:15], exp_inst[24:20], exp_inst[11:7], exp_inst[14:12], exp_inst[31:25]});
            end
            chk("ex_alu_result", ex_alu_result, exp_alu);
            chk("ex_pc_plus4", ex_pc_plus4, exp_pc4);
            chk("ex_branch_target", ex_branch_target, exp_tgt);
            chk("ex_redirect_taken", ex_redirect_taken, exp_taken);
            chk("mem_regs", dut_mem, rst ? memv_t'('0) : exp_mem);
        end
    end

    initial begin
        rst = 1'b1;
        exp_mem = '0;
        drive_random();
        chk_en = 1'b1;
        #1 chk("reset_mem", dut_mem, 192'd0);
        step();
        step();
        rst = 1'b0;
        drive_random();

        repeat (300) begin
            step();
            drive_random();
        end

        step();
        dec_valid = 1'b0;
        id_inst = 32'h0010_0393;
        #1;
        chk("addi_rd", rd_addr, 5'd7);
        chk("addi_ctrl", {reg_write, alu_rs2_imm, alu_op, wb_sel, imm_type}, {1'b1, 1'b1, 4'd0, 2'b00, 3'd0});
        id_inst = 32'h40B5_0533;
        #1 chk("sub_alu_op", alu_op, 4'd1);
        id_inst = 32'h4030_D093;
        #1 chk("srai_alu_op", alu_op, 4'd7);
        id_inst = 32'hFFFF_FFFF;
        #1 chk("illegal_ctrl", dut_dec, 28'd0);

        ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0; ex_use_pc_add = 1'b0;
        ex_alu_rs2_imm = 1'b0; ex_wb_sel = 2'b00;
        ex_alu_op = 4'd3; ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 32'd1; model_ex();
        #1 chk("slt_neg", ex_alu_result, 32'd1);
        ex_alu_op = 4'd4; model_ex();
        #1 chk("sltu_big", ex_alu_result, 32'd0);
        ex_alu_op = 4'd7; ex_rs1 = 32'h8000_0000; ex_rs2 = 32'd4; model_ex();
        #1 chk("sra_sign", ex_alu_result, 32'hF800_0000);

        step();
        ex_branch = 1'b1; ex_branch_op = 3'b001; ex_rs1 = 32'd5; ex_rs2 = 32'd5; model_ex();
        #1 chk("bne_equal", ex_redirect_taken, 1'b0);
        ex_branch_op = 3'b111; ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 32'd1;
        ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF8; model_ex();
        #1 chk("bgeu_taken", ex_redirect_taken, 1'b1);
        chk("bgeu_target", ex_branch_target, 32'h0000_00F8);

        step();
        ex_branch = 1'b0; ex_jalr = 1'b1; ex_rs1 = 32'h1003; ex_imm = 32'd4;
        ex_pc = 32'h40; ex_wb_sel = 2'b10; model_ex();
        #1 chk("jalr_target", ex_branch_target, 32'h1006);
        chk("jalr_taken", ex_redirect_taken, 1'b1);
        step();
        chk("jalr_wb_candidate", mem_wb_candidate, 32'h44);

        drive_random();
        ex_pc = 32'h0000_1234; ex_rd_addr = 5'd9; ex_reg_write = 1'b1; ex_fence = 1'b1;
        model_ex();
        step();
        chk("pre_reset_pc", mem_pc, 32'h0000_1234);
        #2 rst = 1'b1;
        exp_mem = '0;
        #1 chk("async_reset_mem", dut_mem, 192'd0);
        step();
        chk("reset_hold_mem", dut_mem, 192'd0);
        #2 rst = 1'b0;
        step();
        chk("reload_pc", mem_pc, 32'h0000_1234);
        chk("reload_rd", mem_rd_addr, 5'd9);

        repeat (50) begin
            drive_random();
            step();
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
